regfile_mp_sb: RTL and testbench

Parametrised multi-ported integer register file with an integrated per-register scoreboard, the successor to the single-write, two-read pipeline register file. It serves NRD read ports with same-cycle write-to-read bypass from all NWR write ports, hardwires x0, and tracks for each architectural register whether a result is still outstanding and which producer tag owns it. It sits between decode/issue (reads plus allocation) and writeback (writes plus scoreboard release), and replaces the external forward-select input used by the previous generation.

---
 rtl/rv32i_types.sv | 23 ++
 rtl/regfile_scoreboard.sv | 112 +++++++++++
 rtl/regfile_mp_sb.sv | 129 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared integer-pipeline types.
// Holds the default data width and register count, the register-index and
// producer-tag types, and the writeback-port record. The register file
// carries its write ports internally as an array of wb_port_t.
package rv32i_types;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RW    = $clog2(NREGS);
    localparam int TAG_W = 4;

    typedef logic [RW-1:0]    reg_idx_t;
    typedef logic [TAG_W-1:0] prod_tag_t;

    // One writeback lane: strobe, destination, value and producer tag.
    typedef struct packed {
        logic            en;
        reg_idx_t        s;
        logic [XLEN-1:0] v;
        prod_tag_t       tag;
    } wb_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy/tag scoreboard.
// Tracks, for every architectural register, whether a result is outstanding
// and which producer tag owns it. Next-state priority per register is
// reset > flush > allocate > tag-matching release. Reads are combinational
// and see a same-cycle release but not a same-cycle allocate.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_s                NRD packed read selects
//   rd_busy, rd_tag     post-writeback busy bit and owner tag per read port
//   wr_en, wr_s, wr_tag writeback lanes (only the release side is used here)
//   alloc_en/_s/_tag    mark one destination as pending with a new owner
//   flush               clear every busy and tag entry
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int TAG_W = 4,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*RW-1:0]    rd_s,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD*TAG_W-1:0] rd_tag,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*RW-1:0]    wr_s,
    input  logic [NWR*TAG_W-1:0] wr_tag,
    input  logic                 alloc_en,
    input  logic [RW-1:0]        alloc_s,
    input  logic [TAG_W-1:0]     alloc_tag,
    input  logic                 flush
);

    logic             busy_q [NREGS];
    logic [TAG_W-1:0] tag_q  [NREGS];
    logic             rel    [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                // x0 can never be allocated, so it is never busy.
                assign busy_q[gi] = 1'b0;
                assign tag_q[gi]  = '0;
                assign rel[gi]    = 1'b0;
            end else begin : g_xn
                logic             busy_d;
                logic [TAG_W-1:0] tag_d;
                logic             rel_hit;
                logic             alloc_hit;
                logic             busy_r;
                logic [TAG_W-1:0] tag_r;

                // A write releases the register only if it carries the
                // current owner's tag; stale producers leave it busy.
                always_comb begin
                    rel_hit = 1'b0;
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en[p] && wr_s[p*RW +: RW] == RW'(gi) &&
                            wr_tag[p*TAG_W +: TAG_W] == tag_r) begin
                            rel_hit = 1'b1;
                        end
                    end
                end

                assign alloc_hit = alloc_en && (alloc_s == RW'(gi));

                always_comb begin
                    busy_d = busy_r;
                    tag_d  = tag_r;
                    if (flush) begin
                        busy_d = 1'b0;
                        tag_d  = '0;
                    end else if (alloc_hit) begin
                        busy_d = 1'b1;
                        tag_d  = alloc_tag;
                    end else if (rel_hit) begin
                        // Tag returns to 0 so a non-busy entry reads tag 0.
                        busy_d = 1'b0;
                        tag_d  = '0;
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        busy_r <= 1'b0;
                        tag_r  <= '0;
                    end else begin
                        busy_r <= busy_d;
                        tag_r  <= tag_d;
                    end
                end

                assign busy_q[gi] = busy_r;
                assign tag_q[gi]  = tag_r;
                assign rel[gi]    = rel_hit;
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [RW-1:0] sel;
            logic          busy_view;

            assign sel       = rd_s[gi*RW +: RW];
            assign busy_view = !rst && (sel != '0) && busy_q[sel] && !rel[sel];

            assign rd_busy[gi]               = busy_view;
            assign rd_tag[gi*TAG_W +: TAG_W] = busy_view ? tag_q[sel] : '0;
        end
    endgenerate

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-ported integer register file with integrated scoreboard.
// NRD combinational read ports with same-cycle bypass from all NWR write
// ports (highest write-port index wins), hardwired x0, and a per-register
// busy/tag scoreboard fed by decode (allocate) and writeback (release).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rd_s / rd_v                 read selects and bypassed read data
//   rd_busy / rd_tag            outstanding-producer view per read port
//   wr_en, wr_s, wr_v, wr_tag   writeback lanes
//   alloc_en, alloc_s, alloc_tag destination allocation from issue
//   flush                       clear all busy bits; data is kept
module regfile_mp_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int TAG_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_s,
    output logic [NRD*XLEN-1:0]         rd_v,
    output logic [NRD-1:0]              rd_busy,
    output logic [NRD*TAG_W-1:0]        rd_tag,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_s,
    input  logic [NWR*XLEN-1:0]         wr_v,
    input  logic [NWR*TAG_W-1:0]        wr_tag,
    input  logic                        alloc_en,
    input  logic [$clog2(NREGS)-1:0]    alloc_s,
    input  logic [TAG_W-1:0]            alloc_tag,
    input  logic                        flush
);

    import rv32i_types::wb_port_t;
    import rv32i_types::reg_idx_t;

    localparam int RW = $clog2(NREGS);

    wb_port_t [NWR-1:0]     wb;
    logic [NWR-1:0]         sb_wr_en;
    logic [NWR*RW-1:0]      sb_wr_s;
    logic [NWR*TAG_W-1:0]   sb_wr_tag;

    logic [XLEN-1:0] data_q [NREGS];
    logic [XLEN-1:0] data_d [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wb
            assign wb[gi] = '{en:  wr_en[gi],
                              s:   wr_s[gi*RW +: RW],
                              v:   wr_v[gi*XLEN +: XLEN],
                              tag: wr_tag[gi*TAG_W +: TAG_W]};
            assign sb_wr_en[gi]                 = wb[gi].en;
            assign sb_wr_s[gi*RW +: RW]         = wb[gi].s;
            assign sb_wr_tag[gi*TAG_W +: TAG_W] = wb[gi].tag;
        end
    endgenerate

    // Ascending port order makes the highest-index writer the last
    // assignment, which gives it priority on a collision.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            data_d[r] = data_q[r];
        end
        for (int p = 0; p < NWR; p++) begin
            if (wb[p].en && wb[p].s != '0) begin
                data_d[wb[p].s] = wb[p].v;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (rst) begin
                data_q[r] <= '0;
            end else begin
                data_q[r] <= data_d[r];
            end
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            reg_idx_t        sel;
            logic [XLEN-1:0] val;

            assign sel = rd_s[gi*RW +: RW];

            // Combinational writeback-to-decode bypass.
            always_comb begin
                val = data_q[sel];
                for (int p = 0; p < NWR; p++) begin
                    if (wb[p].en && wb[p].s == sel) begin
                        val = wb[p].v;
                    end
                end
                if (rst || sel == '0) begin
                    val = '0;
                end
            end

            assign rd_v[gi*XLEN +: XLEN] = val;
        end
    endgenerate

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .TAG_W (TAG_W),
        .RW    (RW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_s      (rd_s),
        .rd_busy   (rd_busy),
        .rd_tag    (rd_tag),
        .wr_en     (sb_wr_en),
        .wr_s      (sb_wr_s),
        .wr_tag    (sb_wr_tag),
        .alloc_en  (alloc_en),
        .alloc_s   (alloc_s),
        .alloc_tag (alloc_tag),
        .flush     (flush)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed, table-driven bench for regfile_mp_sb (default 32x32, 2R/2W).
// Each record is one clock cycle: inputs are driven after the falling edge,
// outputs are compared just before the next rising edge, and the rising
// edge then commits the cycle.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_s;
    logic [63:0] rd_v;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;
    logic [1:0]  wr_en;
    logic [9:0]  wr_s;
    logic [63:0] wr_v;
    logic [7:0]  wr_tag;
    logic        alloc_en;
    logic [4:0]  alloc_s;
    logic [3:0]  alloc_tag;
    logic        flush;

    regfile_mp_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rd_s      (rd_s),
        .rd_v      (rd_v),
        .rd_busy   (rd_busy),
        .rd_tag    (rd_tag),
        .wr_en     (wr_en),
        .wr_s      (wr_s),
        .wr_v      (wr_v),
        .wr_tag    (wr_tag),
        .alloc_en  (alloc_en),
        .alloc_s   (alloc_s),
        .alloc_tag (alloc_tag),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  rs0, rs1;
        logic [1:0]  we;
        logic [4:0]  ws0, ws1;
        logic [31:0] wv0, wv1;
        logic [3:0]  wt0, wt1;
        logic        ae;
        logic [4:0]  as_;
        logic [3:0]  at;
        logic        fl;
        logic [31:0] ev0, ev1;
        logic [1:0]  eb;
        logic [3:0]  et0, et1;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(
        input logic rst_i, input logic [4:0] rs0, input logic [4:0] rs1,
        input logic [1:0] we, input logic [4:0] ws0, input logic [31:0] wv0,
        input logic [3:0] wt0, input logic [4:0] ws1, input logic [31:0] wv1,
        input logic [3:0] wt1, input logic ae, input logic [4:0] as_,
        input logic [3:0] at, input logic fl,
        input logic [31:0] ev0, input logic [31:0] ev1, input logic [1:0] eb,
        input logic [3:0] et0, input logic [3:0] et1);
        vec_t v;
        v.rst = rst_i; v.rs0 = rs0; v.rs1 = rs1;
        v.we = we; v.ws0 = ws0; v.wv0 = wv0; v.wt0 = wt0;
        v.ws1 = ws1; v.wv1 = wv1; v.wt1 = wt1;
        v.ae = ae; v.as_ = as_; v.at = at; v.fl = fl;
        v.ev0 = ev0; v.ev1 = ev1; v.eb = eb; v.et0 = et0; v.et1 = et1;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
        end
    endtask

    task automatic step(input string tag, input int row, input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        rd_s      = {v.rs1, v.rs0};
        wr_en     = v.we;
        wr_s      = {v.ws1, v.ws0};
        wr_v      = {v.wv1, v.wv0};
        wr_tag    = {v.wt1, v.wt0};
        alloc_en  = v.ae;
        alloc_s   = v.as_;
        alloc_tag = v.at;
        flush     = v.fl;
        #4;
        chk({tag, ".rd_v0"},    row, rd_v[31:0],          v.ev0);
        chk({tag, ".rd_v1"},    row, rd_v[63:32],         v.ev1);
        chk({tag, ".rd_busy"},  row, {30'd0, rd_busy},    {30'd0, v.eb});
        chk({tag, ".rd_tag0"},  row, {28'd0, rd_tag[3:0]}, {28'd0, v.et0});
        chk({tag, ".rd_tag1"},  row, {28'd0, rd_tag[7:4]}, {28'd0, v.et1});
        $display("[TB] %s row %0d rs=%0d/%0d v=%h/%h busy=%b tag=%0d/%0d",
                 tag, row, v.rs0, v.rs1, rd_v[31:0], rd_v[63:32],
                 rd_busy, rd_tag[3:0], rd_tag[7:4]);
    endtask

    vec_t tbl [20];
    vec_t seq [4];

    initial begin
        rst = 1'b1; rd_s = '0; wr_en = '0; wr_s = '0; wr_v = '0; wr_tag = '0;
        alloc_en = 1'b0; alloc_s = '0; alloc_tag = '0; flush = 1'b0;

        //            rst rs0 rs1 we    ws0 wv0            wt0 ws1 wv1     wt1 ae as at fl  ev0    ev1    eb     et0 et1
        // reset: inputs ignored, outputs forced to 0
        tbl[0]  = mk(1, 5, 5, 2'b11, 5, 32'h1234,      0, 5, 32'h5678, 0, 1, 5, 9, 0, 0,     0,     2'b00, 0, 0);
        tbl[1]  = mk(1, 5, 5, 2'b00, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0, 0,     0,     2'b00, 0, 0);
        // x5 reads 0; write to x0 is not bypassed
        tbl[2]  = mk(0, 0, 5, 2'b01, 0, 32'hDEADBEEF,  0, 0, 0,        0, 0, 0, 0, 0, 0,     0,     2'b00, 0, 0);
        // two ports collide on x3: port1 wins in the bypass
        tbl[3]  = mk(0, 0, 3, 2'b11, 3, 32'h11,        0, 3, 32'h22,   0, 0, 0, 0, 0, 0,     32'h22, 2'b00, 0, 0);
        tbl[4]  = mk(0, 3, 3, 2'b00, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0, 32'h22, 32'h22, 2'b00, 0, 0);
        // alloc x7/tag3: invisible this cycle
        tbl[5]  = mk(0, 7, 3, 2'b00, 0, 0,             0, 0, 0,        0, 1, 7, 3, 0, 0,     32'h22, 2'b00, 0, 0);
        // stale tag 2: data bypasses, busy stays
        tbl[6]  = mk(0, 7, 7, 2'b01, 7, 32'h77,        2, 0, 0,        0, 0, 0, 0, 0, 32'h77, 32'h77, 2'b11, 3, 3);
        tbl[7]  = mk(0, 7, 7, 2'b00, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0, 32'h77, 32'h77, 2'b11, 3, 3);
        // matching tag 3 on port1: released in the same cycle
        tbl[8]  = mk(0, 7, 7, 2'b10, 0, 0,             0, 7, 32'h78,   3, 0, 0, 0, 0, 32'h78, 32'h78, 2'b00, 0, 0);
        tbl[9]  = mk(0, 7, 7, 2'b00, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0, 32'h78, 32'h78, 2'b00, 0, 0);
        // x9 owned by tag1, then release tag1 + alloc tag4 together
        tbl[10] = mk(0, 9, 7, 2'b00, 0, 0,             0, 0, 0,        0, 1, 9, 1, 0, 0,     32'h78, 2'b00, 0, 0);
        tbl[11] = mk(0, 9, 7, 2'b01, 9, 32'h99,        1, 0, 0,        0, 1, 9, 4, 0, 32'h99, 32'h78, 2'b00, 0, 0);
        tbl[12] = mk(0, 9, 9, 2'b00, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0, 32'h99, 32'h99, 2'b11, 4, 4);
        // alloc x4, x5, x6
        tbl[13] = mk(0, 4, 5, 2'b00, 0, 0,             0, 0, 0,        0, 1, 4, 5, 0, 0,     0,     2'b00, 0, 0);
        tbl[14] = mk(0, 4, 5, 2'b00, 0, 0,             0, 0, 0,        0, 1, 5, 6, 0, 0,     0,     2'b01, 5, 0);
        tbl[15] = mk(0, 5, 4, 2'b00, 0, 0,             0, 0, 0,        0, 1, 6, 7, 0, 0,     0,     2'b11, 6, 5);
        // flush + alloc x8 + write x10; flush not yet visible
        tbl[16] = mk(0, 6, 9, 2'b01, 10, 32'hA0,       0, 0, 0,        0, 1, 8, 2, 1, 0,     32'h99, 2'b11, 7, 4);
        tbl[17] = mk(0, 8, 4, 2'b00, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0, 0,     0,     2'b00, 0, 0);
        tbl[18] = mk(0, 9, 10, 2'b00, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 32'h99, 32'hA0, 2'b00, 0, 0);
        tbl[19] = mk(0, 6, 5, 2'b00, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0, 0,     0,     2'b00, 0, 0);

        for (int i = 0; i < 20; i++) begin
            step("tbl", i, tbl[i]);
        end

        // Reset in the middle of operation: x2 busy with 0x55, then reset.
        // alloc beats the same-cycle tag-0 release of x2.
        seq[0] = mk(0, 2, 0, 2'b01, 2, 32'h55,         0, 0, 0,        0, 1, 2, 1, 0, 32'h55, 0,    2'b00, 0, 0);
        seq[1] = mk(0, 2, 2, 2'b00, 0, 0,              0, 0, 0,        0, 0, 0, 0, 0, 32'h55, 32'h55, 2'b11, 1, 1);
        // reset with a write and alloc to x3 that must be discarded
        seq[2] = mk(1, 2, 3, 2'b01, 3, 32'h33,         0, 0, 0,        0, 1, 3, 5, 0, 0,     0,     2'b00, 0, 0);
        seq[3] = mk(0, 2, 3, 2'b00, 0, 0,              0, 0, 0,        0, 0, 0, 0, 0, 0,     0,     2'b00, 0, 0);

        for (int i = 0; i < 4; i++) begin
            step("rst_seq", i, seq[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
